multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
- Multi-cycle instruction sequencer for the 16-bit CPU.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB from the 5-bit opcode.
- Handshakes with instruction and data memory, and emits one-cycle strobes (IR load, PC increment/load, register write, memory read/write) that gate the combinational control-unit signals.
- Handles SYSCALL halt and illegal-opcode trap.

Parameters:
- TIMEOUT, 15, cycles waited for imem_ack/dmem_ack before trapping (used only with WAIT_TIMEOUT_EN).
- TO_W, 4, width of the timeout counter; TIMEOUT must be < 2**TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- op  in  5  opcode from IR; stable from DECODE until return to FETCH.
- brtaken  in  1  branch condition from datapath; sampled in EXEC for BLTZ/BZ/BGTZ.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- resume  in  1  leave HALT.
- imem_rd  out  1  instruction fetch request.
- irwt  out  1  IR load strobe.
- pcinc  out  1  PC+1 strobe.
- pcwt  out  1  PC load strobe (jump/branch target).
- dmem_rd  out  1  data read request (LW).
- dmem_wt  out  1  data write request (SW).
- regwt_en  out  1  register-file write strobe.
- state  out  3  current state.
- halted  out  1  in HALT.
- trap  out  1  in TRAP.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6; codes 7 go to TRAP.
- Reset: while rstn=0 on a clock edge, state<=FETCH and timeout counter<=0. All outputs are 0 while rstn is low. The first imem_rd appears in the cycle after rstn rises.
- Outputs are decoded from the state register plus ack/brtaken inputs (same-cycle).
- FETCH:
  - imem_rd=1.
  - On imem_ack=1: irwt=1 and pcinc=1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch the op class internally.
  - Illegal op (11100, 11101, 11110) goes to TRAP.
  - SYSCALL (11111) goes to HALT.
  - All other ops go to EXEC.
- EXEC:
  - R-type/I-type ALU ops (00000-10011) go to WB.
  - LW (11010) and SW (11011) go to MEM.
  - J (10100) and JR (10101): pcwt=1, then FETCH.
  - JAL (10110): pcwt=1, then WB (link write).
  - BLTZ/BZ/BGTZ (10111-11001): pcwt=brtaken, then FETCH.
- MEM:
  - LW: dmem_rd=1 until dmem_ack, then WB.
  - SW: dmem_wt=1 until dmem_ack, then FETCH.
  - Never assert dmem_rd and dmem_wt together.
- WB: regwt_en=1 for exactly one cycle, then FETCH.
- HALT:
  - halted=1.
  - resume=1 goes to FETCH; otherwise hold.
- TRAP:
  - trap=1.
  - Exit only by reset.
- Latency with zero-wait memory (ack in the same cycle as the request):
  - ALU op and JAL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - J/JR/branch: 3 cycles.
- Each wait-state cycle adds one cycle.
- Ack outside the matching request state is ignored.
- Strobes (irwt, pcinc, pcwt, regwt_en) are never asserted for more than one cycle per instruction.
- resume outside HALT is ignored.
- Reset mid-instruction abandons the instruction with no strobes emitted.

Optional Feature:
- Macro WAIT_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on entry to FETCH/MEM and on any ack.
  - It increments each cycle a request is held without ack.
  - When the counter equals TIMEOUT and ack is still 0, the next state is TRAP and the request drops.
  - An ack in the same cycle as the counter reaching TIMEOUT wins; no trap.
- When undefined: no counter; the sequencer waits indefinitely.

Test Plan:
- Reset, then op=00000 (ADD) with imem_ack tied 1: states 0,1,2,4,0. irwt/pcinc pulse in cycle 1, regwt_en in cycle 4. dmem_rd, dmem_wt and pcwt stay 0.
- LW (11010) with dmem_ack delayed 3 cycles: dmem_rd high 4 cycles in MEM, then WB with a single regwt_en pulse. Total 8 cycles.
- BZ (11000) with brtaken=1: pcwt=1 in EXEC, back to FETCH after 3 cycles. Repeat with brtaken=0: pcwt stays 0.
- SYSCALL (11111): HALT with halted=1 held for 10 cycles. Pulse resume: FETCH next cycle. Op 11101: trap=1 held until rstn=0.
- Reset asserted in MEM during SW: dmem_wt drops to 0 while rstn is low. After release, state=0 and imem_rd=1.
- With WAIT_TIMEOUT_EN and TIMEOUT=15: imem_ack held 0 gives TRAP after 16 FETCH cycles. An ack on the 16th cycle gives DECODE instead.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer for the 16-bit CPU.
// Optional macro WAIT_TIMEOUT_EN traps when a memory ack takes longer than TIMEOUT cycles.
module multicycle_seq #(
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:0] op,
   input  logic       brtaken,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   input  logic       resume,
   output logic       imem_rd,
   output logic       irwt,
   output logic       pcinc,
   output logic       pcwt,
   output logic       dmem_rd,
   output logic       dmem_wt,
   output logic       regwt_en,
   output logic [2:0] state,
   output logic       halted,
   output logic       trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_ALU,
      C_JMP,
      C_JAL,
      C_BR,
      C_LW,
      C_SW,
      C_ILL,
      C_SYS
   } opClass_t;

   if (TIMEOUT >= (1 << TO_W)) begin : g_badTimeout
      $error("multicycle_seq: TIMEOUT must fit in TO_W bits");
   end

   function automatic opClass_t classify(input logic [4:0] opc);
      opClass_t c;
      if (opc <= 5'b10011) begin
         c = C_ALU;
      end else begin
         case (opc)
            5'b10100, 5'b10101:          c = C_JMP;
            5'b10110:                    c = C_JAL;
            5'b10111, 5'b11000, 5'b11001: c = C_BR;
            5'b11010:                    c = C_LW;
            5'b11011:                    c = C_SW;
            5'b11111:                    c = C_SYS;
            default:                     c = C_ILL;
         endcase
      end
      return c;
   endfunction

   state_t   r_state;
   state_t   w_nextState;
   opClass_t r_opClass;
   opClass_t w_opClass;
   logic     w_expired;

   logic w_imemRd;
   logic w_irwt;
   logic w_pcinc;
   logic w_pcwt;
   logic w_dmemRd;
   logic w_dmemWt;
   logic w_regwt;
   logic w_halted;
   logic w_trap;

   assign w_opClass = classify(op);

   // The op class is captured in DECODE so EXEC/MEM do not depend on op decode timing.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_FETCH;
         r_opClass <= C_ALU;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_DECODE) begin
            r_opClass <= w_opClass;
         end
      end
   end

`ifdef WAIT_TIMEOUT_EN
   logic [TO_W-1:0] r_toCount;
   logic            w_waiting;

   assign w_waiting = ((r_state == S_FETCH) && !imem_ack) ||
                      ((r_state == S_MEM) && !dmem_ack &&
                       ((r_opClass == C_LW) || (r_opClass == C_SW)));
   assign w_expired = w_waiting && (r_toCount == TO_W'(TIMEOUT));

   // Any cycle without an outstanding unanswered request clears the count.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_toCount <= '0;
      end else if (w_waiting) begin
         r_toCount <= r_toCount + 1'b1;
      end else begin
         r_toCount <= '0;
      end
   end
`else
   assign w_expired = 1'b0;
`endif

   always_comb begin
      w_nextState = r_state;
      w_imemRd    = 1'b0;
      w_irwt      = 1'b0;
      w_pcinc     = 1'b0;
      w_pcwt      = 1'b0;
      w_dmemRd    = 1'b0;
      w_dmemWt    = 1'b0;
      w_regwt     = 1'b0;
      w_halted    = 1'b0;
      w_trap      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imemRd = 1'b1;
            if (imem_ack) begin
               w_irwt      = 1'b1;
               w_pcinc     = 1'b1;
               w_nextState = S_DECODE;
            end else if (w_expired) begin
               w_nextState = S_TRAP;
            end
         end
         S_DECODE: begin
            case (w_opClass)
               C_ILL:   w_nextState = S_TRAP;
               C_SYS:   w_nextState = S_HALT;
               default: w_nextState = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (r_opClass)
               C_ALU:      w_nextState = S_WB;
               C_LW, C_SW: w_nextState = S_MEM;
               C_JMP: begin
                  w_pcwt      = 1'b1;
                  w_nextState = S_FETCH;
               end
               C_JAL: begin
                  w_pcwt      = 1'b1;
                  w_nextState = S_WB;
               end
               C_BR: begin
                  w_pcwt      = brtaken;
                  w_nextState = S_FETCH;
               end
               default:    w_nextState = S_TRAP;
            endcase
         end
         S_MEM: begin
            if (r_opClass == C_LW) begin
               w_dmemRd = 1'b1;
               if (dmem_ack) begin
                  w_nextState = S_WB;
               end else if (w_expired) begin
                  w_nextState = S_TRAP;
               end
            end else if (r_opClass == C_SW) begin
               w_dmemWt = 1'b1;
               if (dmem_ack) begin
                  w_nextState = S_FETCH;
               end else if (w_expired) begin
                  w_nextState = S_TRAP;
               end
            end else begin
               w_nextState = S_TRAP;
            end
         end
         S_WB: begin
            w_regwt     = 1'b1;
            w_nextState = S_FETCH;
         end
         S_HALT: begin
            w_halted = 1'b1;
            if (resume) begin
               w_nextState = S_FETCH;
            end
         end
         S_TRAP: begin
            w_trap = 1'b1;
         end
         default: begin
            w_nextState = S_TRAP;
         end
      endcase
   end

   // Everything is forced low while reset is held, including mid-instruction.
   assign imem_rd  = rstn & w_imemRd;
   assign irwt     = rstn & w_irwt;
   assign pcinc    = rstn & w_pcinc;
   assign pcwt     = rstn & w_pcwt;
   assign dmem_rd  = rstn & w_dmemRd;
   assign dmem_wt  = rstn & w_dmemWt;
   assign regwt_en = rstn & w_regwt;
   assign halted   = rstn & w_halted;
   assign trap     = rstn & w_trap;
   assign state    = rstn ? r_state : 3'd0;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed scenarios plus randomized
// instruction streams compared against a cycle-trace model built from opcode rules.
module tb_multicycle_seq;

   logic       clk = 1'b0;
   logic       rstn;
   logic [4:0] op;
   logic       brtaken;
   logic       imem_ack;
   logic       dmem_ack;
   logic       resume;
   logic       imem_rd;
   logic       irwt;
   logic       pcinc;
   logic       pcwt;
   logic       dmem_rd;
   logic       dmem_wt;
   logic       regwt_en;
   logic [2:0] state;
   logic       halted;
   logic       trap;

   int nChecks;
   int nPass;

   // Output bundle order: {imem_rd, irwt, pcinc, pcwt, dmem_rd, dmem_wt, regwt_en}
   localparam logic [6:0] O_NONE  = 7'b0000000;
   localparam logic [6:0] O_FETCH = 7'b1000000;
   localparam logic [6:0] O_FACK  = 7'b1110000;
   localparam logic [6:0] O_PCWT  = 7'b0001000;
   localparam logic [6:0] O_DRD   = 7'b0000100;
   localparam logic [6:0] O_DWT   = 7'b0000010;
   localparam logic [6:0] O_RW    = 7'b0000001;

   typedef struct packed {
      logic [2:0] st;
      logic [6:0] outs;
      logic       iaFix;
      logic       ia;
      logic       daFix;
      logic       da;
   } cyc_t;

   multicycle_seq #(.TIMEOUT(15), .TO_W(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .op       (op),
      .brtaken  (brtaken),
      .imem_ack (imem_ack),
      .dmem_ack (dmem_ack),
      .resume   (resume),
      .imem_rd  (imem_rd),
      .irwt     (irwt),
      .pcinc    (pcinc),
      .pcwt     (pcwt),
      .dmem_rd  (dmem_rd),
      .dmem_wt  (dmem_wt),
      .regwt_en (regwt_en),
      .state    (state),
      .halted   (halted),
      .trap     (trap)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] obs();
      return {state, imem_rd, irwt, pcinc, pcwt, dmem_rd, dmem_wt, regwt_en, halted, trap};
   endfunction

   function automatic logic [11:0] ev(input logic [2:0] st, input logic [6:0] o,
                                      input logic h, input logic t);
      return {st, o, h, t};
   endfunction

   function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] o,
                               input logic iaFix, input logic ia,
                               input logic daFix, input logic da);
      cyc_t c;
      c.st    = st;
      c.outs  = o;
      c.iaFix = iaFix;
      c.ia    = ia;
      c.daFix = daFix;
      c.da    = da;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      resume   = 1'b1;
      brtaken  = 1'b1;
      op       = 5'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nChecks++;
         if (obs() !== 12'd0) $display("[TB] FAIL reset_low%0d: got %h expected %h", i, obs(), 12'd0);
         else nPass++;
         tick();
      end
      rstn     = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      resume   = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FETCH, 1'b0, 1'b0))
         $display("[TB] FAIL reset_release: got %h expected %h", obs(), ev(3'd0, O_FETCH, 1'b0, 1'b0));
      else nPass++;
      tick();
   endtask

   task automatic test_alu();
      logic [11:0] expv [5];
      logic        ia   [5];
      expv = '{ev(3'd0, O_FACK, 1'b0, 1'b0), ev(3'd1, O_NONE, 1'b0, 1'b0),
               ev(3'd2, O_NONE, 1'b0, 1'b0), ev(3'd4, O_RW, 1'b0, 1'b0),
               ev(3'd0, O_FETCH, 1'b0, 1'b0)};
      ia   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      op       = 5'b00000;
      brtaken  = 1'($urandom);
      dmem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         imem_ack = ia[i];
         @(negedge clk);
         nChecks++;
         if (obs() !== expv[i]) $display("[TB] FAIL alu_cycle%0d: got %h expected %h", i, obs(), expv[i]);
         else nPass++;
         tick();
      end
   endtask

   task automatic test_lw();
      logic [11:0] expv [9];
      logic        ia   [9];
      logic        da   [9];
      int          rdCycles;
      int          rwPulses;
      expv = '{ev(3'd0, O_FACK, 1'b0, 1'b0), ev(3'd1, O_NONE, 1'b0, 1'b0),
               ev(3'd2, O_NONE, 1'b0, 1'b0), ev(3'd3, O_DRD, 1'b0, 1'b0),
               ev(3'd3, O_DRD, 1'b0, 1'b0), ev(3'd3, O_DRD, 1'b0, 1'b0),
               ev(3'd3, O_DRD, 1'b0, 1'b0), ev(3'd4, O_RW, 1'b0, 1'b0),
               ev(3'd0, O_FETCH, 1'b0, 1'b0)};
      ia   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      da   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      rdCycles = 0;
      rwPulses = 0;
      op       = 5'b11010;
      for (int i = 0; i < 9; i++) begin
         imem_ack = ia[i];
         dmem_ack = da[i];
         @(negedge clk);
         if (dmem_rd === 1'b1) rdCycles++;
         if (regwt_en === 1'b1) rwPulses++;
         nChecks++;
         if (obs() !== expv[i]) $display("[TB] FAIL lw_cycle%0d: got %h expected %h", i, obs(), expv[i]);
         else nPass++;
         tick();
      end
      nChecks++;
      if (rdCycles !== 4) $display("[TB] FAIL lw_dmem_rd_cycles: got %0d expected 4", rdCycles);
      else nPass++;
      nChecks++;
      if (rwPulses !== 1) $display("[TB] FAIL lw_regwt_pulses: got %0d expected 1", rwPulses);
      else nPass++;
   endtask

   task automatic test_branch();
      logic [11:0] expv [4];
      for (int b = 1; b >= 0; b--) begin
         expv = '{ev(3'd0, O_FACK, 1'b0, 1'b0), ev(3'd1, O_NONE, 1'b0, 1'b0),
                  ev(3'd2, (b == 1) ? O_PCWT : O_NONE, 1'b0, 1'b0),
                  ev(3'd0, O_FETCH, 1'b0, 1'b0)};
         op       = 5'b11000;
         brtaken  = 1'(b);
         dmem_ack = 1'b0;
         for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            @(negedge clk);
            nChecks++;
            if (obs() !== expv[i])
               $display("[TB] FAIL bz_br%0d_cycle%0d: got %h expected %h", b, i, obs(), expv[i]);
            else nPass++;
            tick();
         end
      end
   endtask

   task automatic test_halt();
      op       = 5'b11111;
      resume   = 1'b0;
      dmem_ack = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FACK, 1'b0, 1'b0))
         $display("[TB] FAIL halt_fetch: got %h expected %h", obs(), ev(3'd0, O_FACK, 1'b0, 1'b0));
      else nPass++;
      tick();
      imem_ack = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd1, O_NONE, 1'b0, 1'b0))
         $display("[TB] FAIL halt_decode: got %h expected %h", obs(), ev(3'd1, O_NONE, 1'b0, 1'b0));
      else nPass++;
      tick();
      for (int i = 0; i < 10; i++) begin
         imem_ack = 1'($urandom);
         dmem_ack = 1'($urandom);
         @(negedge clk);
         nChecks++;
         if (obs() !== ev(3'd5, O_NONE, 1'b1, 1'b0))
            $display("[TB] FAIL halt_hold%0d: got %h expected %h", i, obs(), ev(3'd5, O_NONE, 1'b1, 1'b0));
         else nPass++;
         tick();
      end
      resume = 1'b1;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd5, O_NONE, 1'b1, 1'b0))
         $display("[TB] FAIL halt_resume_cycle: got %h expected %h", obs(), ev(3'd5, O_NONE, 1'b1, 1'b0));
      else nPass++;
      tick();
      resume   = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FETCH, 1'b0, 1'b0))
         $display("[TB] FAIL halt_exit: got %h expected %h", obs(), ev(3'd0, O_FETCH, 1'b0, 1'b0));
      else nPass++;
      tick();
   endtask

   task automatic test_trap();
      op       = 5'b11101;
      imem_ack = 1'b1;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FACK, 1'b0, 1'b0))
         $display("[TB] FAIL trap_fetch: got %h expected %h", obs(), ev(3'd0, O_FACK, 1'b0, 1'b0));
      else nPass++;
      tick();
      imem_ack = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         imem_ack = 1'($urandom);
         dmem_ack = 1'($urandom);
         resume   = 1'($urandom);
         @(negedge clk);
         nChecks++;
         if (obs() !== ev(3'd6, O_NONE, 1'b0, 1'b1))
            $display("[TB] FAIL trap_hold%0d: got %h expected %h", i, obs(), ev(3'd6, O_NONE, 1'b0, 1'b1));
         else nPass++;
         tick();
      end
      rstn = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== 12'd0) $display("[TB] FAIL trap_under_reset: got %h expected %h", obs(), 12'd0);
      else nPass++;
      tick();
      rstn     = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      resume   = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FETCH, 1'b0, 1'b0))
         $display("[TB] FAIL trap_after_reset: got %h expected %h", obs(), ev(3'd0, O_FETCH, 1'b0, 1'b0));
      else nPass++;
      tick();
   endtask

   task automatic test_reset_mid();
      op       = 5'b11011;
      dmem_ack = 1'b0;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         nChecks++;
         if (obs() !== ev(3'd3, O_DWT, 1'b0, 1'b0))
            $display("[TB] FAIL sw_mem%0d: got %h expected %h", i, obs(), ev(3'd3, O_DWT, 1'b0, 1'b0));
         else nPass++;
         if (i == 0) tick();
      end
      rstn = 1'b0;
      #1;
      nChecks++;
      if (obs() !== 12'd0) $display("[TB] FAIL sw_reset_drop: got %h expected %h", obs(), 12'd0);
      else nPass++;
      tick();
      @(negedge clk);
      nChecks++;
      if (obs() !== 12'd0) $display("[TB] FAIL sw_reset_hold: got %h expected %h", obs(), 12'd0);
      else nPass++;
      tick();
      rstn = 1'b1;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd0, O_FETCH, 1'b0, 1'b0))
         $display("[TB] FAIL sw_reset_release: got %h expected %h", obs(), ev(3'd0, O_FETCH, 1'b0, 1'b0));
      else nPass++;
      tick();
   endtask

`ifdef WAIT_TIMEOUT_EN
   task automatic test_timeout();
      int  fetchCycles;
      bit  done;
      rstn     = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      op       = 5'b00000;
      tick();
      rstn        = 1'b1;
      fetchCycles = 0;
      done        = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (state === 3'd6) done = 1'b1;
         else begin
            if (state === 3'd0 && imem_rd === 1'b1) fetchCycles++;
            tick();
         end
      end
      nChecks++;
      if (fetchCycles !== 16) $display("[TB] FAIL timeout_fetch_cycles: got %0d expected 16", fetchCycles);
      else nPass++;
      nChecks++;
      if (obs() !== ev(3'd6, O_NONE, 1'b0, 1'b1))
         $display("[TB] FAIL timeout_trap: got %h expected %h", obs(), ev(3'd6, O_NONE, 1'b0, 1'b1));
      else nPass++;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         imem_ack = (i == 15);
         @(negedge clk);
         nChecks++;
         if (obs() !== ev(3'd0, (i == 15) ? O_FACK : O_FETCH, 1'b0, 1'b0))
            $display("[TB] FAIL timeout_ack_cycle%0d: got %h expected %h", i, obs(),
                     ev(3'd0, (i == 15) ? O_FACK : O_FETCH, 1'b0, 1'b0));
         else nPass++;
         tick();
      end
      imem_ack = 1'b0;
      @(negedge clk);
      nChecks++;
      if (obs() !== ev(3'd1, O_NONE, 1'b0, 1'b0))
         $display("[TB] FAIL timeout_ack_wins: got %h expected %h", obs(), ev(3'd1, O_NONE, 1'b0, 1'b0));
      else nPass++;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask
`else
   task automatic test_timeout();
      int fetchCycles;
      imem_ack    = 1'b0;
      dmem_ack    = 1'b0;
      fetchCycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (state === 3'd0 && imem_rd === 1'b1 && trap === 1'b0) fetchCycles++;
         tick();
      end
      nChecks++;
      if (fetchCycles !== 40) $display("[TB] FAIL wait_forever: got %0d expected 40", fetchCycles);
      else nPass++;
   endtask
`endif

   task automatic test_random();
      cyc_t       q[$];
      logic [4:0] o;
      logic       br;
      int         iw;
      int         dw;
      bit         isAlu, isLoad, isStore, isJump, isJal, isBr;
      for (int n = 0; n < 60; n++) begin
         o       = 5'($urandom_range(0, 27));
         br      = 1'($urandom);
         iw      = int'($urandom_range(0, 3));
         dw      = int'($urandom_range(0, 3));
         isAlu   = (o <= 5'd19);
         isJump  = (o == 5'd20) || (o == 5'd21);
         isJal   = (o == 5'd22);
         isBr    = (o >= 5'd23) && (o <= 5'd25);
         isLoad  = (o == 5'd26);
         isStore = (o == 5'd27);
         q.delete();
         for (int k = 0; k < iw; k++) q.push_back(mk(3'd0, O_FETCH, 1'b1, 1'b0, 1'b0, 1'b0));
         q.push_back(mk(3'd0, O_FACK, 1'b1, 1'b1, 1'b0, 1'b0));
         q.push_back(mk(3'd1, O_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
         q.push_back(mk(3'd2, (isJump || isJal || (isBr && br)) ? O_PCWT : O_NONE,
                        1'b0, 1'b0, 1'b0, 1'b0));
         if (isLoad || isStore) begin
            for (int k = 0; k < dw; k++)
               q.push_back(mk(3'd3, isLoad ? O_DRD : O_DWT, 1'b0, 1'b0, 1'b1, 1'b0));
            q.push_back(mk(3'd3, isLoad ? O_DRD : O_DWT, 1'b0, 1'b0, 1'b1, 1'b1));
         end
         if (isAlu || isJal || isLoad) q.push_back(mk(3'd4, O_RW, 1'b0, 1'b0, 1'b0, 1'b0));
         op      = o;
         brtaken = br;
         for (int k = 0; k < q.size(); k++) begin
            imem_ack = q[k].iaFix ? q[k].ia : 1'($urandom);
            dmem_ack = q[k].daFix ? q[k].da : 1'($urandom);
            resume   = 1'($urandom);
            @(negedge clk);
            nChecks++;
            if (obs() !== ev(q[k].st, q[k].outs, 1'b0, 1'b0))
               $display("[TB] FAIL rand_op%0h_cycle%0d: got %h expected %h", o, k, obs(),
                        ev(q[k].st, q[k].outs, 1'b0, 1'b0));
            else nPass++;
            tick();
         end
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      resume   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nChecks  = 0;
      nPass    = 0;
      rstn     = 1'b0;
      op       = 5'd0;
      brtaken  = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      resume   = 1'b0;
      test_reset();
      test_alu();
      test_lw();
      test_branch();
      test_halt();
      test_trap();
      test_reset_mid();
      test_random();
      test_timeout();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
